sop_sweep_ctrl: RTL and testbench

//   Sequencer for the 4-input SOP evaluator y = a&b&c | ~a&~c | d.
//   On start, drives all 16 input vectors into one shared evaluator instance in order.

---
 rtl/sop_sweep_ctrl_pkg.sv | 20 ++
 rtl/sop_sweep_ctrl_if.sv | 37 +++
 rtl/sop_sweep_ctrl_eval.sv | 16 +
 rtl/sop_sweep_ctrl.sv | 162 ++++++++++++++++
 tb/tb_sop_sweep_ctrl.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/sop_sweep_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// sop_sweep_ctrl_pkg
//   Shared definitions for the SOP sweep controller: FSM state encodings,
//   vector count and the golden truth table of y = a&b&c | ~a&~c | d.
//   No ports (package).
// -----------------------------------------------------------------------------
package sop_sweep_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam int          VEC_W   = 4;
  localparam int          N_VEC   = 16;
  localparam logic [15:0] GOLD_TT = 16'hEABB;

endpackage

// File: rtl/sop_sweep_ctrl_if.sv
// -----------------------------------------------------------------------------
// sop_sweep_ctrl_if
//   Control/result bundle between a sweep requester (master) and the sweep
//   controller (slave).
//   master -> slave : start, abort, exp_tt
//   slave -> master : vec, busy, done, tt, ones_cnt, pass, first_fail, fail_vld
//   Parameter CNT_W sets the width of ones_cnt.
// -----------------------------------------------------------------------------
interface sop_sweep_ctrl_if
  import sop_sweep_ctrl_pkg::*;
#(
  parameter int CNT_W = 5
);

  logic                  start;
  logic                  abort;
  logic [N_VEC-1:0]      exp_tt;
  logic [VEC_W-1:0]      vec;
  logic                  busy;
  logic                  done;
  logic [N_VEC-1:0]      tt;
  logic [CNT_W-1:0]      ones_cnt;
  logic                  pass;
  logic [VEC_W-1:0]      first_fail;
  logic                  fail_vld;

  modport master (
    output start, abort, exp_tt,
    input  vec, busy, done, tt, ones_cnt, pass, first_fail, fail_vld
  );

  modport slave (
    input  start, abort, exp_tt,
    output vec, busy, done, tt, ones_cnt, pass, first_fail, fail_vld
  );

endinterface

// File: rtl/sop_sweep_ctrl_eval.sv
// -----------------------------------------------------------------------------
// sop_sweep_ctrl_eval
//   Combinational 4-input SOP evaluator: y = a&b&c | ~a&~c | d.
//   Ports: a, b, c, d (in), y (out).
// -----------------------------------------------------------------------------
module sop_sweep_ctrl_eval (
  input  logic a,
  input  logic b,
  input  logic c,
  input  logic d,
  output logic y
);

  assign y = (a & b & c) | (~a & ~c) | d;

endmodule

// File: rtl/sop_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// sop_sweep_ctrl
//   Sweeps all 16 input vectors through one SOP evaluator, captures y into a
//   truth table, counts the ones and compares the table with exp_tt.
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bus    sop_sweep_ctrl_if.slave (start/abort/exp_tt in; vec, busy, done,
//            tt, ones_cnt, pass, first_fail, fail_vld out)
//   Parameters:
//     SETTLE_CYC  cycles each vector is held before y is sampled (>= 1)
//     CNT_W       width of ones_cnt
//   Optional feature macro: SWEEP_FAIL_LOG_EN (records the lowest mismatching
//   vector in first_fail/fail_vld; tied to 0 when undefined).
// -----------------------------------------------------------------------------
module sop_sweep_ctrl
  import sop_sweep_ctrl_pkg::*;
#(
  parameter int SETTLE_CYC = 1,
  parameter int CNT_W      = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sop_sweep_ctrl_if.slave      bus
);

  // Settle counter runs 0..SETTLE_CYC-1; keep at least one bit.
  localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [VEC_W-1:0] LAST_VEC = VEC_W'(N_VEC - 1);

  state_t           state;
  state_t           next_state;
  logic [SW-1:0]    settle_cnt;
  logic [VEC_W-1:0] vec;
  logic [N_VEC-1:0] tt;
  logic [CNT_W-1:0] ones_cnt;
  logic             done;
  logic             pass;
  logic             busy;
  logic             y;
  logic             settle_done;
  logic             start_go;
  logic             sample_go;

  sop_sweep_ctrl_eval u_eval (
    .a (vec[3]),
    .b (vec[2]),
    .c (vec[1]),
    .d (vec[0]),
    .y (y)
  );

  assign settle_done = (settle_cnt == SW'(SETTLE_CYC - 1));
  // abort has priority over start in IDLE and cancels any capture in SAMPLE.
  assign start_go    = (state == ST_IDLE)   && bus.start && !bus.abort;
  assign sample_go   = (state == ST_SAMPLE) && !bus.abort;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (start_go) next_state = ST_DRIVE;
      end
      ST_DRIVE: begin
        if (bus.abort)        next_state = ST_IDLE;
        else if (settle_done) next_state = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        if (bus.abort)             next_state = ST_IDLE;
        else if (vec == LAST_VEC)  next_state = ST_DONE;
        else                       next_state = ST_DRIVE;
      end
      ST_DONE: next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  // Datapath registers. done is registered on the DONE->IDLE edge, which
  // places it one cycle after the last sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      settle_cnt <= '0;
      vec        <= '0;
      tt         <= '0;
      ones_cnt   <= '0;
      done       <= 1'b0;
      pass       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_go) begin
            settle_cnt <= '0;
            vec        <= '0;
            tt         <= '0;
            ones_cnt   <= '0;
            pass       <= 1'b0;
          end
        end
        ST_DRIVE: begin
          if (!bus.abort)
            settle_cnt <= settle_done ? '0 : settle_cnt + SW'(1);
        end
        ST_SAMPLE: begin
          if (sample_go) begin
            tt[vec]    <= y;
            ones_cnt   <= ones_cnt + CNT_W'(y);
            settle_cnt <= '0;
            if (vec != LAST_VEC) vec <= vec + VEC_W'(1);
          end
        end
        ST_DONE: begin
          done <= 1'b1;
          pass <= (tt == bus.exp_tt);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    busy = (state == ST_DRIVE) || (state == ST_SAMPLE);
  end

  assign bus.vec      = vec;
  assign bus.busy     = busy;
  assign bus.done     = done;
  assign bus.tt       = tt;
  assign bus.ones_cnt = ones_cnt;
  assign bus.pass     = pass;

`ifdef SWEEP_FAIL_LOG_EN
  logic [VEC_W-1:0] first_fail;
  logic             fail_vld;

  // Only the first mismatch is kept, so first_fail is the lowest failing vec.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first_fail <= '0;
      fail_vld   <= 1'b0;
    end else if (start_go) begin
      first_fail <= '0;
      fail_vld   <= 1'b0;
    end else if (sample_go && (y != bus.exp_tt[vec]) && !fail_vld) begin
      first_fail <= vec;
      fail_vld   <= 1'b1;
    end
  end

  assign bus.first_fail = first_fail;
  assign bus.fail_vld   = fail_vld;
`else
  assign bus.first_fail = '0;
  assign bus.fail_vld   = 1'b0;
`endif

endmodule

// File: tb/tb_sop_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sop_sweep_ctrl
//   Directed bench for sop_sweep_ctrl: one instance with SETTLE_CYC=1 and one
//   with SETTLE_CYC=3 sharing clock and reset.
// -----------------------------------------------------------------------------
module tb_sop_sweep_ctrl;
  import sop_sweep_ctrl_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   lat;
  int   pulses;

  always #5 clk = ~clk;

  sop_sweep_ctrl_if #(.CNT_W(5)) bus1 ();
  sop_sweep_ctrl_if #(.CNT_W(5)) bus2 ();

  sop_sweep_ctrl #(.SETTLE_CYC(1), .CNT_W(5)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  sop_sweep_ctrl #(.SETTLE_CYC(3), .CNT_W(5)) dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2)
  );

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic ab, input logic [15:0] e);
    bus1.start  = s;
    bus1.abort  = ab;
    bus1.exp_tt = e;
  endtask

  // Start is sampled by edge E0; returns just after E0.
  task automatic startSweep(input logic [15:0] e);
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, e);
    @(posedge clk);
    #1 bus1.start = 1'b0;
  endtask

  // Watches a fixed window; lat is the first cycle (after E0) with done high.
  task automatic waitDone(input int limit, output int l, output int p);
    l = -1;
    p = 0;
    for (int n = 1; n <= limit; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus1.done) begin
        p++;
        if (l < 0) l = n;
      end
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    applyStimulus(1'b0, 1'b0, GOLD_TT);
    bus2.start  = 1'b0;
    bus2.abort  = 1'b0;
    bus2.exp_tt = GOLD_TT;
    #1;
    checkOutput("rst_vec",        bus1.vec,        0);
    checkOutput("rst_busy",       bus1.busy,       0);
    checkOutput("rst_done",       bus1.done,       0);
    checkOutput("rst_tt",         bus1.tt,         0);
    checkOutput("rst_ones",       bus1.ones_cnt,   0);
    checkOutput("rst_pass",       bus1.pass,       0);
    checkOutput("rst_first_fail", bus1.first_fail, 0);
    checkOutput("rst_fail_vld",   bus1.fail_vld,   0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] test 1: golden sweep");
    startSweep(GOLD_TT);
    checkOutput("t1_busy_start", bus1.busy, 1);
    waitDone(40, lat, pulses);
    checkOutput("t1_latency", lat,           33);
    checkOutput("t1_pulses",  pulses,        1);
    checkOutput("t1_tt",      bus1.tt,       16'hEABB);
    checkOutput("t1_ones",    bus1.ones_cnt, 11);
    checkOutput("t1_pass",    bus1.pass,     1);
    checkOutput("t1_vec",     bus1.vec,      15);
    checkOutput("t1_busy_end", bus1.busy,    0);

    $display("[TB] test 3: abort mid-sweep");
    startSweep(GOLD_TT);
    repeat (4) @(posedge clk);
    @(negedge clk);
    checkOutput("t3_busy_pre", bus1.busy, 1);
    bus1.abort = 1'b1;
    @(posedge clk);
    #1 bus1.abort = 1'b0;
    @(negedge clk);
    checkOutput("t3_busy_post", bus1.busy,     0);
    checkOutput("t3_tt_part",   bus1.tt,       16'h0003);
    checkOutput("t3_ones_part", bus1.ones_cnt, 2);
    checkOutput("t3_vec_part",  bus1.vec,      2);
    waitDone(40, lat, pulses);
    checkOutput("t3_no_done", pulses,    0);
    checkOutput("t3_pass",    bus1.pass, 0);
    startSweep(GOLD_TT);
    waitDone(40, lat, pulses);
    checkOutput("t3_resweep_lat",  lat,       33);
    checkOutput("t3_resweep_pass", bus1.pass, 1);

    $display("[TB] abort wins over start in IDLE");
    @(negedge clk);
    applyStimulus(1'b1, 1'b1, GOLD_TT);
    @(posedge clk);
    #1 applyStimulus(1'b0, 1'b0, GOLD_TT);
    @(negedge clk);
    checkOutput("idle_abort_busy", bus1.busy, 0);
    checkOutput("idle_abort_pass", bus1.pass, 1);

    $display("[TB] test 2: mismatching golden table");
    startSweep(16'hEABA);
    waitDone(40, lat, pulses);
    checkOutput("t2_latency", lat,       33);
    checkOutput("t2_pass",    bus1.pass, 0);
    checkOutput("t2_tt",      bus1.tt,   16'hEABB);
`ifdef SWEEP_FAIL_LOG_EN
    checkOutput("t2_fail_vld",   bus1.fail_vld,   1);
    checkOutput("t2_first_fail", bus1.first_fail, 0);
`else
    checkOutput("t2_fail_vld",   bus1.fail_vld,   0);
    checkOutput("t2_first_fail", bus1.first_fail, 0);
`endif

    $display("[TB] test 4: start re-pulsed during sweep");
    startSweep(GOLD_TT);
    lat    = -1;
    pulses = 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus1.done) begin
        pulses++;
        if (lat < 0) lat = n;
      end
      bus1.start = (n == 2) || (n == 19);
    end
    checkOutput("t4_latency", lat,       33);
    checkOutput("t4_pulses",  pulses,    1);
    checkOutput("t4_pass",    bus1.pass, 1);

    $display("[TB] test 5: reset mid-sweep");
    startSweep(GOLD_TT);
    repeat (10) @(posedge clk);
    @(negedge clk);
    checkOutput("t5_tt_pre",   bus1.tt,       16'h001B);
    checkOutput("t5_ones_pre", bus1.ones_cnt, 4);
    checkOutput("t5_vec_pre",  bus1.vec,      5);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("t5_vec_rst",  bus1.vec,      0);
    checkOutput("t5_tt_rst",   bus1.tt,       0);
    checkOutput("t5_ones_rst", bus1.ones_cnt, 0);
    checkOutput("t5_busy_rst", bus1.busy,     0);
    checkOutput("t5_pass_rst", bus1.pass,     0);
    waitDone(3, lat, pulses);
    checkOutput("t5_no_done", pulses, 0);
    rst_n = 1'b1;
    startSweep(GOLD_TT);
    waitDone(40, lat, pulses);
    checkOutput("t5_latency", lat,           33);
    checkOutput("t5_pass",    bus1.pass,     1);
    checkOutput("t5_ones",    bus1.ones_cnt, 11);

    $display("[TB] test 6: SETTLE_CYC=3 instance");
    @(negedge clk);
    bus2.start = 1'b1;
    @(posedge clk);
    #1 bus2.start = 1'b0;
    lat    = -1;
    pulses = 0;
    for (int n = 1; n <= 80; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (n == 3) checkOutput("t6_vec_c3", bus2.vec, 0);
      if (n == 4) checkOutput("t6_vec_c4", bus2.vec, 1);
      if (n == 7) checkOutput("t6_vec_c7", bus2.vec, 1);
      if (n == 8) checkOutput("t6_vec_c8", bus2.vec, 2);
      if (bus2.done) begin
        pulses++;
        if (lat < 0) lat = n;
      end
    end
    checkOutput("t6_latency", lat,           65);
    checkOutput("t6_pulses",  pulses,        1);
    checkOutput("t6_pass",    bus2.pass,     1);
    checkOutput("t6_tt",      bus2.tt,       16'hEABB);
    checkOutput("t6_ones",    bus2.ones_cnt, 11);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
